// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM states, ACK/NACK bus
// levels and a helper that maps a bit to drive onto SDA into the open-drain
// enable (1 = pull low).
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        ACK_DEV,
        REGIDX,
        ACK_IDX,
        WDATA,
        ACK_WR,
        RDATA,
        MACK,
        WAIT_STOP
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Open-drain: a 0 on the wire needs the pull-down enabled, a 1 is a release.
    function automatic logic pull_for(input logic lvl);
        return ~lvl;
    endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// Synchronizes one raw bus line and debounces it: the filtered level only
// follows the input after FILT_LEN consecutive equal samples.
// Latency: 2 sync cycles + FILT_LEN cycles; no backpressure (free-running).
// Ports: clk/rst, raw_i (async line), lvl_o (filtered level),
//        rise_o/fall_o (one-cycle pulses, aligned with the lvl_o change).
module i2c_sync_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        // cnt_q holds how many differing samples preceded this one; any equal
        // sample restarts the run, so short glitches never reach filt_q.
        if (sync2_q != filt_q) begin
            if (cnt_q == 4'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
    end

    // Idle bus is high, so everything resets to 1 and no edge appears on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign lvl_o  = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing NUM_REGS 8-bit registers: index write, auto-increment
// data write/read, repeated START, host-side combinational read port.
// Latency: bus-bit timed; sda_oe moves 1 clk after a filtered SCL fall; no backpressure.
// Ports: clk/rst, scl_i/sda_i raw bus, sda_oe open-drain pull-down enable,
//        host_raddr/host_rdata read port, reg_we/reg_waddr/reg_wdata write
//        strobe, wr_done (STOP after a write), busy (START..STOP).
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NUM_REGS = 16,
    parameter int         FILT_LEN = 3,
    localparam int        IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic [IDX_W-1:0] host_raddr,
    output logic [7:0]       host_rdata,
    output logic             reg_we,
    output logic [IDX_W-1:0] reg_waddr,
    output logic [7:0]       reg_wdata,
    output logic             wr_done,
    output logic             busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (scl_i),
        .lvl_o  (scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (sda_i),
        .lvl_o  (sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // Both filters share one latency, so scl_lvl is coherent with the SDA edge.
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       tx_q, tx_d;
    logic             mack_q, mack_d;
    logic             rw_q, rw_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             reg_we_q, reg_we_d;
    logic [IDX_W-1:0] reg_waddr_q, reg_waddr_d;
    logic [7:0]       reg_wdata_q, reg_wdata_d;
    logic             wr_done_q, wr_done_d;
    logic             wrote_q, wrote_d;
    logic             busy_q, busy_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic [IDX_W-1:0] ptr_inc;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        mack_d      = mack_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        wr_done_d   = 1'b0;
        wrote_d     = wrote_q;
        busy_d      = busy_q;
        regs_d      = regs_q;
        ptr_inc     = (ptr_q == IDX_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

        if (start_det) begin
            // Repeated START lands here too; ptr and wrote_q carry across it.
            state_d   = DEVADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            wr_done_d = wrote_q;
            wrote_d   = 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                DEVADDR, REGIDX, WDATA: begin
                    if (bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                RDATA: begin
                    if (bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                MACK:    mack_d = sda_lvl;
                default: ;
            endcase
        end else if (scl_fall) begin
            // The first fall after a START has bit_cnt_q == 0, so it is ignored.
            unique case (state_q)
                DEVADDR: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (shreg_q[7:1] == DEV_ADDR) begin
                            state_d  = ACK_DEV;
                            rw_d     = shreg_q[0];
                            sda_oe_d = pull_for(ACK);
                        end else begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = pull_for(NACK);
                        end
                    end
                end
                ACK_DEV: begin
                    if (rw_q) begin
                        state_d  = RDATA;
                        tx_d     = regs_q[ptr_q];
                        sda_oe_d = pull_for(regs_q[ptr_q][7]);
                    end else begin
                        state_d  = REGIDX;
                        sda_oe_d = 1'b0;
                    end
                    bit_cnt_d = '0;
                end
                REGIDX: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if ({1'b0, shreg_q} < 9'(NUM_REGS)) begin
                            ptr_d    = shreg_q[IDX_W-1:0];
                            state_d  = ACK_IDX;
                            sda_oe_d = pull_for(ACK);
                        end else begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = pull_for(NACK);
                        end
                    end
                end
                ACK_IDX, ACK_WR: begin
                    state_d   = WDATA;
                    bit_cnt_d = '0;
                    sda_oe_d  = 1'b0;
                end
                WDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        regs_d[ptr_q] = shreg_q;
                        reg_we_d      = 1'b1;
                        reg_waddr_d   = ptr_q;
                        reg_wdata_d   = shreg_q;
                        ptr_d         = ptr_inc;
                        wrote_d       = 1'b1;
                        state_d       = ACK_WR;
                        bit_cnt_d     = '0;
                        sda_oe_d      = pull_for(ACK);
                    end
                end
                RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        // Hand SDA to the master for its ACK/NACK.
                        state_d   = MACK;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                    end else begin
                        // bit_cnt_q bits already clocked out; next is bit 7-bit_cnt_q.
                        sda_oe_d = pull_for(tx_q[~bit_cnt_q[2:0]]);
                    end
                end
                MACK: begin
                    if (mack_q == ACK) begin
                        ptr_d     = ptr_inc;
                        state_d   = RDATA;
                        tx_d      = regs_q[ptr_inc];
                        sda_oe_d  = pull_for(regs_q[ptr_inc][7]);
                        bit_cnt_d = '0;
                    end else begin
                        state_d  = WAIT_STOP;
                        sda_oe_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            tx_q        <= '0;
            mack_q      <= NACK;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            wr_done_q   <= 1'b0;
            wrote_q     <= 1'b0;
            busy_q      <= 1'b0;
            regs_q      <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            mack_q      <= mack_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            wr_done_q   <= wr_done_d;
            wrote_q     <= wrote_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
        end
    end

    // Reads the registered array, so a same-cycle bus write shows up next cycle.
    assign host_rdata = regs_q[host_raddr];
    assign sda_oe     = sda_oe_q;
    assign reg_we     = reg_we_q;
    assign reg_waddr  = reg_waddr_q;
    assign reg_wdata  = reg_wdata_q;
    assign wr_done    = wr_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
module tb_i2c_reg_target;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_gl = 1'b0, sda_gl = 1'b0;
    logic       glitch_en = 1'b0;
    logic       scl_i, sda_i, sda_oe;
    logic [3:0] host_raddr = 4'd0;
    logic [7:0] host_rdata;
    logic       reg_we;
    logic [3:0] reg_waddr;
    logic [7:0] reg_wdata;
    logic       wr_done, busy;

    int checks = 0, failures = 0;
    int wr_done_cnt = 0, we_cnt = 0, oe_cnt = 0;
    logic [11:0] exp_q[$];        // {index, data} of expected reg_we strobes
    logic [7:0]  exp_regs[16];
    logic [11:0] item;

    // Open-drain wire: master level, optional glitch, target pull-down.
    assign scl_i = scl_m ^ scl_gl;
    assign sda_i = (sda_m ^ sda_gl) & ~sda_oe;

    always #5 clk = ~clk;

    i2c_reg_target #(.DEV_ADDR(7'h42), .NUM_REGS(16), .FILT_LEN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .reg_we     (reg_we),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .wr_done    (wr_done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (sda_oe)  oe_cnt++;
            if (wr_done) wr_done_cnt++;
            if (reg_we) begin
                we_cnt++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_reg_we: observed idx=%0d data=0x%0h expected no write",
                           reg_waddr, reg_wdata);
                end
                if (exp_q.size() != 0) begin
                    item = exp_q.pop_front();
                    check("reg_waddr", 32'(reg_waddr), 32'(item[11:8]));
                    check("reg_wdata", 32'(reg_wdata), 32'(item[7:0]));
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch_scl();
        scl_gl = 1'b1;
        @(negedge clk);
        scl_gl = 1'b0;
    endtask

    task automatic glitch_sda();
        sda_gl = 1'b1;
        @(negedge clk);
        sda_gl = 1'b0;
    endtask

    // One SCL period starting and ending with SCL low; returns the wire level
    // sampled in the middle of the high phase.
    task automatic send_bit(input logic b, output logic line);
        sda_m = b;
        if (glitch_en) begin clks(Q/2); glitch_scl(); clks(Q/2); end
        else clks(Q);
        scl_m = 1'b1;
        clks(Q);
        line = sda_i;
        if (glitch_en) begin glitch_sda(); clks(2); glitch_scl(); clks(Q-3); end
        else clks(Q);
        scl_m = 1'b0;
        clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
        send_bit(mack, dummy);
    endtask

    task automatic start_c();
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic rstart_c();
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b1; clks(2*Q);
    endtask

    task automatic host_rd(input logic [3:0] idx, output logic [7:0] d);
        host_raddr = idx;
        #1;
        d = host_rdata;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic [3:0] at, input string tag);
        logic a;
        exp_q.push_back({at, b});
        exp_regs[at] = b;
        send_byte(b, a);
        check(tag, 32'(a), 32'(0));
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         oe0, we0;

        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;

        // Reset state
        clks(3);
        check("rst_sda_oe", 32'(sda_oe), 32'(0));
        check("rst_reg_we", 32'(reg_we), 32'(0));
        check("rst_wr_done", 32'(wr_done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        host_rd(4'd3, d);
        check("rst_reg3", 32'(d), 32'(0));
        rst = 1'b0;
        clks(5);

        // Write idx 3: A5, 5A
        start_c();
        check("busy_after_start", 32'(busy), 32'(1));
        send_byte(8'h84, a); check("ack_dev_w", 32'(a), 32'(0));
        send_byte(8'h03, a); check("ack_idx3", 32'(a), 32'(0));
        wr_byte(8'hA5, 4'd3, "ack_wd_a5");
        wr_byte(8'h5A, 4'd4, "ack_wd_5a");
        stop_c();
        check("wr_done_cnt1", 32'(wr_done_cnt), 32'(1));
        check("busy_after_stop", 32'(busy), 32'(0));
        host_rd(4'd3, d); check("reg3", 32'(d), 32'(8'hA5));
        host_rd(4'd4, d); check("reg4", 32'(d), 32'(8'h5A));

        // Preload idx 1,2 so the wrap read returns distinctive data
        start_c();
        send_byte(8'h84, a); check("ack_dev_pre", 32'(a), 32'(0));
        send_byte(8'h01, a); check("ack_idx1", 32'(a), 32'(0));
        wr_byte(8'hC3, 4'd1, "ack_wd_c3");
        wr_byte(8'h3C, 4'd2, "ack_wd_3c");
        stop_c();
        check("wr_done_cnt2", 32'(wr_done_cnt), 32'(2));

        // Wrap write 15 -> 0, repeated START, read from ptr=1
        start_c();
        send_byte(8'h84, a); check("ack_dev_wrap", 32'(a), 32'(0));
        send_byte(8'h0F, a); check("ack_idx15", 32'(a), 32'(0));
        wr_byte(8'h11, 4'd15, "ack_wd_11");
        wr_byte(8'h22, 4'd0, "ack_wd_22");
        rstart_c();
        check("busy_after_sr", 32'(busy), 32'(1));
        send_byte(8'h85, a); check("ack_dev_r", 32'(a), 32'(0));
        read_byte(1'b0, d); check("rd_reg1", 32'(d), 32'(exp_regs[1]));
        read_byte(1'b1, d); check("rd_reg2", 32'(d), 32'(exp_regs[2]));
        stop_c();
        check("wr_done_cnt3", 32'(wr_done_cnt), 32'(3));

        // Foreign address: never driven, nothing written
        oe0 = oe_cnt; we0 = we_cnt;
        start_c();
        send_byte(8'h90, a); check("nack_addr90", 32'(a), 32'(1));
        send_byte(8'h00, a); check("ignored_byte", 32'(a), 32'(1));
        stop_c();
        check("no_oe_foreign", 32'(oe_cnt), 32'(oe0));
        check("no_we_foreign", 32'(we_cnt), 32'(we0));
        check("wr_done_foreign", 32'(wr_done_cnt), 32'(3));

        // Out-of-range index: NACK, ptr stays 2 (last read position)
        start_c();
        send_byte(8'h84, a); check("ack_dev_oor", 32'(a), 32'(0));
        send_byte(8'h10, a); check("nack_idx16", 32'(a), 32'(1));
        stop_c();
        check("no_we_oor", 32'(we_cnt), 32'(we0));
        check("wr_done_oor", 32'(wr_done_cnt), 32'(3));
        start_c();
        send_byte(8'h85, a); check("ack_dev_r2", 32'(a), 32'(0));
        read_byte(1'b1, d); check("ptr_unchanged", 32'(d), 32'(exp_regs[2]));
        stop_c();

        // Reset in the middle of a data byte
        start_c();
        send_byte(8'h84, a); check("ack_dev_rst", 32'(a), 32'(0));
        send_byte(8'h05, a); check("ack_idx5", 32'(a), 32'(0));
        for (int i = 0; i < 3; i++) send_bit(1'b1, a);
        sda_m = 1'b1;
        clks(Q/2);
        check("busy_before_rst", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_mid_sda_oe", 32'(sda_oe), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        host_rd(4'd3, d); check("rst_mid_reg3", 32'(d), 32'(0));
        host_rd(4'd1, d); check("rst_mid_reg1", 32'(d), 32'(0));
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        clks(3);
        rst = 1'b0;
        clks(Q);
        send_bit(1'b0, a);
        send_bit(1'b1, a);
        stop_c();
        check("post_rst_busy", 32'(busy), 32'(0));
        check("post_rst_wr_done", 32'(wr_done_cnt), 32'(3));
        start_c();
        send_byte(8'h84, a); check("ack_dev_after_rst", 32'(a), 32'(0));
        send_byte(8'h07, a); check("ack_idx7", 32'(a), 32'(0));
        wr_byte(8'h77, 4'd7, "ack_wd_77");
        stop_c();
        check("wr_done_cnt4", 32'(wr_done_cnt), 32'(4));

        // One-cycle glitches on SCL and SDA throughout a write
        glitch_en = 1'b1;
        start_c();
        send_byte(8'h84, a); check("ack_dev_gl", 32'(a), 32'(0));
        send_byte(8'h08, a); check("ack_idx8_gl", 32'(a), 32'(0));
        wr_byte(8'h96, 4'd8, "ack_wd_96_gl");
        stop_c();
        glitch_en = 1'b0;
        check("wr_done_cnt5", 32'(wr_done_cnt), 32'(5));

        // Full register image against the model
        for (int i = 0; i < 16; i++) begin
            host_rd(4'(i), d);
            check($sformatf("final_reg%0d", i), 32'(d), 32'(exp_regs[i]));
        end
        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42: 7-bit I2C device address the block answers to.
REQ-002 SHALL have parameter NUM_REGS, default 16, range 2..256: number of 8-bit registers; index width IDX_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter FILT_LEN, default 3, range 1..8: glitch-filter length in clk cycles on SCL and SDA.
REQ-004 Port clk, in, 1: system clock, at least 16x the SCL rate; everything is synchronous to it.
REQ-005 Port rst, in, 1: asynchronous, active-high reset.
REQ-006 Port scl_i, in, 1: raw I2C clock (asynchronous).
REQ-007 Port sda_i, in, 1: raw I2C data (asynchronous).
REQ-008 Port sda_oe, out, 1: 1 = pull SDA low, 0 = release; the pad is open-drain outside this block.
REQ-009 Port host_raddr, in, IDX_W: host-side register read index.
REQ-010 Port host_rdata, out, 8: combinational read of register[host_raddr].
REQ-011 Port reg_we, out, 1: one-cycle pulse per committed I2C write.
REQ-012 Port reg_waddr, out, IDX_W: index of the committed write; valid while reg_we=1.
REQ-013 Port reg_wdata, out, 8: data of the committed write; valid while reg_we=1.
REQ-014 Port wr_done, out, 1: one-cycle pulse at STOP if the transaction wrote at least one byte.
REQ-015 Port busy, out, 1: high from START until STOP.

Function
REQ-016 SCL and SDA SHALL pass through a 2-flop synchronizer, then a FILT_LEN-stable filter; the filtered level changes only after FILT_LEN consecutive equal samples.
REQ-017 START = filtered SDA falls while SCL=1; STOP = filtered SDA rises while SCL=1; both are detected in any state and take priority over bit processing.
REQ-018 Data bits SHALL be sampled on a filtered SCL rise, MSB first; sda_oe SHALL change only on a filtered SCL fall, one clk after the fall is detected.
REQ-019 FSM states: IDLE, DEVADDR, ACK_DEV, REGIDX, ACK_IDX, WDATA, ACK_WR, RDATA, MACK, WAIT_STOP.
REQ-020 START (including repeated START) from any state -> DEVADDR, bit counter = 0; STOP from any state -> IDLE, with sda_oe released.
REQ-021 After 8 bits in DEVADDR: address match -> ACK_DEV (drive low for one SCL period); mismatch -> WAIT_STOP, never driving.
REQ-022 After ACK_DEV: R/W=0 -> REGIDX; R/W=1 -> RDATA, shifting out register[ptr].
REQ-023 REGIDX byte < NUM_REGS -> ptr := byte, ACK_IDX, then WDATA; byte >= NUM_REGS -> NACK, WAIT_STOP, ptr unchanged.
REQ-024 In WDATA, on the SCL fall after the 8th bit: register[ptr] := byte; reg_we pulses with reg_waddr=ptr and reg_wdata=byte; ACK is driven; ptr := ptr+1.
REQ-025 In RDATA, the byte is loaded on the SCL fall that ends ACK_DEV or MACK; a 0 bit drives sda_oe=1 and a 1 bit releases.
REQ-026 In MACK, master ACK (SDA=0) -> ptr := ptr+1, RDATA; NACK -> WAIT_STOP.
REQ-027 ptr SHALL wrap from NUM_REGS-1 to 0 on every increment.
REQ-028 A repeated START keeps ptr, so write-index-then-Sr-read works.
REQ-029 An I2C write and a host read of the same index in the same cycle SHALL return the old value; the new value is returned from the next cycle.

Reset
REQ-030 rst=1 SHALL immediately set: state=IDLE, sda_oe=0, reg_we=0, wr_done=0, busy=0, ptr=0, all registers=8'h00, synchronizer and filter flops=1 (idle bus).
REQ-031 Reset mid-transaction SHALL abandon it; after release, the block ignores bus activity until the next START.

Structure
REQ-032 Package i2c_pkg SHALL hold the FSM state enum and the constants ACK=1'b0 and NACK=1'b1.
REQ-033 Sub-module i2c_sync_filter (parameter FILT_LEN) SHALL be instantiated once each for SCL and SDA, outputting the filtered level, rise pulse and fall pulse.

Verification
REQ-034 Write 0x84, idx 0x03, data 0xA5 0x5A, STOP -> ACKs on all bytes; reg_we at idx 3 then 4; host_rdata[3]=0xA5 and [4]=0x5A; one wr_done pulse.
REQ-035 Write idx 0x0F data 0x11 0x22, then Sr, 0x85, read 2 bytes (ACK, NACK) -> writes go to 15 then 0 (wrap); the read returns reg[1], reg[2].
REQ-036 Address 0x90 -> no ACK, sda_oe stays 0 through STOP, no reg_we.
REQ-037 Idx 0x10 with NUM_REGS=16 -> NACK on the index byte; no write; ptr unchanged.
REQ-038 Assert rst mid-byte of a write -> sda_oe=0 and registers=0 immediately; the following full transaction succeeds.
REQ-039 1-cycle SCL glitches with FILT_LEN=3 -> no bit shifts and register contents unchanged.
